// File: rtl/systolic_seq_pkg.sv
// rtl/systolic_seq_pkg.sv - shared types and defaults for the systolic array sequencer
package systolic_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_W,
      S_LOAD_I,
      S_COMPUTE,
      S_DRAIN,
      S_DONE
   } seq_state_e;

   localparam int BITWIDTH_DEF       = 4;
   localparam int OUTWIDTH_DEF       = 8;
   localparam int NELEM_DEF          = 16;
   localparam int COMPUTE_CYCLES_DEF = 10;
   localparam int FIFO_DEPTH_DEF     = 4;

   // One extra bit so the counter can hold NELEM itself, not just NELEM-1.
   function automatic int cnt_width(input int n);
      return $clog2(n) + 1;
   endfunction

   localparam int ELEM_CNT_W = cnt_width(NELEM_DEF);

endpackage

// File: rtl/systolic_seq_fifo.sv
// rtl/systolic_seq_fifo.sv - first-word fall-through result FIFO, power-of-2 depth
module systolic_seq_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    rd_q, wr_q;
   logic [CW-1:0]    cnt_q;
   logic             do_pop, do_push;

   assign empty  = (cnt_q == '0);
   assign full   = (cnt_q == DEPTH_C);
   assign count  = cnt_q;
   assign dout   = mem_q[rd_q];
   // A pop frees the head slot this cycle, so a push into a full FIFO is still taken.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop)  rd_q <= rd_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/systolic_seq_ctrl.sv
// rtl/systolic_seq_ctrl.sv - load/compute/drain sequencer for a 4x4 systolic array
module systolic_seq_ctrl
   import systolic_seq_pkg::*;
#(
   parameter int BITWIDTH       = BITWIDTH_DEF,
   parameter int OUTWIDTH       = OUTWIDTH_DEF,
   parameter int NELEM          = NELEM_DEF,
   parameter int COMPUTE_CYCLES = COMPUTE_CYCLES_DEF,
   parameter int FIFO_DEPTH     = FIFO_DEPTH_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                keep_w,
   output logic                busy,
   output logic                done,
   input  logic [BITWIDTH-1:0] in_data,
   input  logic                in_valid,
   output logic                in_ready,
   output logic [BITWIDTH-1:0] sa_data_in,
   output logic                sa_load_weights,
   output logic                sa_load_inputs,
   output logic                sa_store_outputs,
   input  logic [OUTWIDTH-1:0] sa_results,
   input  logic                sa_valid_out,
   output logic [OUTWIDTH-1:0] out_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                err_unexp
);

   localparam int CW = cnt_width(NELEM);
   localparam int KW = $clog2(COMPUTE_CYCLES + 1);
   localparam int FW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0] LAST_ELEM = CW'(NELEM - 1);
   localparam logic [CW-1:0] ALL_ELEM  = CW'(NELEM);
   localparam logic [KW-1:0] LAST_CYC  = KW'(COMPUTE_CYCLES - 1);
   localparam logic [FW:0]   DEPTH_C   = (FW + 1)'(FIFO_DEPTH);

   seq_state_e      state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [KW-1:0]   ccnt_q, ccnt_d;
   logic [FW-1:0]   outst_q, outst_d;
   logic            err_q, err_d;
   logic            wres_q, wres_d;

   logic [OUTWIDTH-1:0] f_dout;
   logic [FW-1:0]       f_count;
   logic                f_full, f_empty, f_push, f_pop;
   logic                ack, room;

   // Reserve a FIFO slot for every store still in flight so no result can be refused.
   assign room = !f_full && (({1'b0, f_count} + {1'b0, outst_q}) < DEPTH_C);

   always_comb begin
      state_d          = state_q;
      cnt_d            = cnt_q;
      ccnt_d           = ccnt_q;
      wres_d           = wres_q;
      busy             = (state_q != S_IDLE);
      done             = 1'b0;
      in_ready         = 1'b0;
      sa_load_weights  = 1'b0;
      sa_load_inputs   = 1'b0;
      sa_store_outputs = 1'b0;
      sa_data_in       = '0;
      case (state_q)
         S_IDLE: begin
            if (start) state_d = (keep_w && wres_q) ? S_LOAD_I : S_LOAD_W;
         end
         S_LOAD_W: begin
            in_ready = 1'b1;
            if (in_valid) begin
               sa_load_weights = 1'b1;
               sa_data_in      = in_data;
               if (cnt_q == LAST_ELEM) begin
                  cnt_d   = '0;
                  wres_d  = 1'b1;
                  state_d = S_LOAD_I;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_LOAD_I: begin
            in_ready = 1'b1;
            if (in_valid) begin
               sa_load_inputs = 1'b1;
               sa_data_in     = in_data;
               if (cnt_q == LAST_ELEM) begin
                  cnt_d   = '0;
                  ccnt_d  = '0;
                  state_d = S_COMPUTE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_COMPUTE: begin
            if (ccnt_q == LAST_CYC) begin
               ccnt_d  = '0;
               state_d = S_DRAIN;
            end else begin
               ccnt_d = ccnt_q + 1'b1;
            end
         end
         S_DRAIN: begin
            if (cnt_q != ALL_ELEM) begin
               if (room) begin
                  sa_store_outputs = 1'b1;
                  cnt_d            = cnt_q + 1'b1;
               end
            end else if ((outst_q == '0) && f_empty) begin
               cnt_d   = '0;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      ack     = sa_valid_out && (outst_q != '0);
      outst_d = outst_q;
      case ({sa_store_outputs, ack})
         2'b10:   outst_d = outst_q + 1'b1;
         2'b01:   outst_d = outst_q - 1'b1;
         default: outst_d = outst_q;
      endcase
      err_d = err_q || (sa_valid_out && (outst_q == '0));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         ccnt_q  <= '0;
         outst_q <= '0;
         err_q   <= 1'b0;
         wres_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ccnt_q  <= ccnt_d;
         outst_q <= outst_d;
         err_q   <= err_d;
         wres_q  <= wres_d;
      end
   end

   assign f_push    = ack;
   assign out_valid = !f_empty;
   assign f_pop     = out_valid && out_ready;
   assign out_data  = f_empty ? '0 : f_dout;
   assign err_unexp = err_q;

   systolic_seq_fifo #(
      .WIDTH (OUTWIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (f_push),
      .pop   (f_pop),
      .din   (sa_results),
      .dout  (f_dout),
      .count (f_count),
      .full  (f_full),
      .empty (f_empty)
   );

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// tb/tb_systolic_seq_ctrl.sv - randomized self-checking bench for systolic_seq_ctrl
module tb_systolic_seq_ctrl;

   localparam int NELEM = 16;
   localparam int CC    = 10;

   logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, keep_w = 1'b0;
   logic       in_valid = 1'b0, out_ready = 1'b0, sa_valid_out = 1'b0;
   logic [3:0] in_data = '0;
   logic [7:0] sa_results = '0;
   logic       busy, done, in_ready, sa_load_weights, sa_load_inputs, sa_store_outputs;
   logic       out_valid, err_unexp;
   logic [3:0] sa_data_in;
   logic [7:0] out_data;

   int checks = 0, errors = 0;
   bit spur = 1'b0;
   logic [7:0] exp_res[$], got_out[$];
   logic [3:0] sent_q[$], got_ld[$];
   int mon_nw = 0, mon_ni = 0, mon_nst = 0, mon_nd = 0;
   int cyc = 0, last_ld_cyc = 0, first_st_cyc = 0;
   bit armed = 1'b0;

   systolic_seq_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start(start), .keep_w(keep_w),
      .busy(busy), .done(done), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .sa_data_in(sa_data_in), .sa_load_weights(sa_load_weights), .sa_load_inputs(sa_load_inputs),
      .sa_store_outputs(sa_store_outputs), .sa_results(sa_results), .sa_valid_out(sa_valid_out),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .err_unexp(err_unexp)
   );

   always #5 clk = ~clk;

   // Array model: one random result per store, presented exactly one cycle later.
   always begin : array_model
      logic       st;
      logic [7:0] r;
      @(negedge clk);
      st = rst_n && sa_store_outputs;
      @(posedge clk);
      #1;
      if (st) begin
         r = 8'($urandom_range(0, 255));
         sa_results = r; sa_valid_out = 1'b1;
         exp_res.push_back(r);
      end else if (spur) begin
         sa_results = 8'hA5; sa_valid_out = 1'b1;
      end else begin
         sa_valid_out = 1'b0; sa_results = 8'($urandom);
      end
   end

   always @(negedge clk) begin
      cyc++;
      if (rst_n) begin
         if (sa_load_weights) begin mon_nw++; got_ld.push_back(sa_data_in); last_ld_cyc = cyc; armed = 1'b1; end
         if (sa_load_inputs)  begin mon_ni++; got_ld.push_back(sa_data_in); last_ld_cyc = cyc; armed = 1'b1; end
         if (sa_store_outputs) begin
            mon_nst++;
            if (armed) begin first_st_cyc = cyc; armed = 1'b0; end
         end
         if (done) mon_nd++;
         if (out_valid && out_ready) got_out.push_back(out_data);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic stream(input int n, input bit gaps);
      int acc, g;
      acc = 0; g = 0;
      while (acc < n && g < 400) begin
         in_valid = gaps ? ((g % 2) == 0) : 1'b1;
         in_data  = 4'($urandom_range(0, 15));
         @(negedge clk);
         if (in_valid && in_ready) begin sent_q.push_back(in_data); acc++; end
         @(posedge clk);
         #1;
         g++;
      end
      in_valid = 1'b0;
   endtask

   task automatic pulse_start(input bit kw);
      @(posedge clk); #1;
      start = 1'b1; keep_w = kw;
      @(posedge clk); #1;
      start = 1'b0; keep_w = 1'b0;
   endtask

   task automatic do_job(input bit kw, input bit gaps, input int rmode, input int ntx,
                         output int nw, output int ni, output int nst, output int nd,
                         output int nout, output int ld_bad, output int out_bad,
                         output int bp_st, output bit bp_ov, output bit tmo);
      int w0, i0, s0, d0, q0, g0, o0, e0, n;
      w0 = mon_nw; i0 = mon_ni; s0 = mon_nst; d0 = mon_nd;
      q0 = sent_q.size(); g0 = got_ld.size(); o0 = got_out.size(); e0 = exp_res.size();
      out_ready = (rmode != 1);
      pulse_start(kw);
      stream(ntx, gaps);
      bp_st = 0; bp_ov = 1'b0;
      if (rmode == 1) begin
         repeat (40) @(posedge clk);
         #1;
         bp_st = mon_nst - s0; bp_ov = out_valid; out_ready = 1'b1;
      end
      tmo = 1'b1;
      for (int k = 0; k < 600; k++) begin
         if (rmode == 2) out_ready = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
         if (mon_nd != d0) begin tmo = 1'b0; break; end
      end
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      nw = mon_nw - w0; ni = mon_ni - i0; nst = mon_nst - s0; nd = mon_nd - d0;
      nout = got_out.size() - o0;
      n = sent_q.size() - q0;
      ld_bad = (got_ld.size() - g0 == n) ? 0 : 1000;
      for (int k = 0; k < n; k++)
         if (g0 + k < got_ld.size() && got_ld[g0 + k] !== sent_q[q0 + k]) ld_bad++;
      n = exp_res.size() - e0;
      out_bad = (nout == n) ? 0 : 1000;
      for (int k = 0; k < n; k++)
         if (o0 + k < got_out.size() && got_out[o0 + k] !== exp_res[e0 + k]) out_bad++;
   endtask

   task automatic test_reset();
      logic [18:0] z;
      rst_n = 1'b0; start = 1'b1; in_valid = 1'b1; in_data = 4'hF;
      @(negedge clk);
      z = {busy, done, in_ready, sa_load_weights, sa_load_inputs, sa_store_outputs, out_valid, sa_data_in, out_data};
      checks++; if (z !== '0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", z); end
      checks++; if (err_unexp !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err_unexp); end
      @(posedge clk); #1;
      rst_n = 1'b1; start = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
   endtask

   task automatic test_full_job();
      int nw, ni, nst, nd, nout, lb, ob, bs; bit bo, tmo;
      do_job(1'b0, 1'b0, 0, 2 * NELEM, nw, ni, nst, nd, nout, lb, ob, bs, bo, tmo);
      checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL full_timeout: no done pulse within bound"); end
      checks++; if (nw !== NELEM) begin errors++; $display("FAIL full_weights: got %0d expected %0d", nw, NELEM); end
      checks++; if (ni !== NELEM) begin errors++; $display("FAIL full_inputs: got %0d expected %0d", ni, NELEM); end
      checks++; if (nst !== NELEM) begin errors++; $display("FAIL full_stores: got %0d expected %0d", nst, NELEM); end
      checks++; if (nd !== 1) begin errors++; $display("FAIL full_done: got %0d pulse cycles expected 1", nd); end
      checks++; if (lb !== 0) begin errors++; $display("FAIL full_load_data: got %0d bad expected 0", lb); end
      checks++; if (nout !== NELEM) begin errors++; $display("FAIL full_out_count: got %0d expected %0d", nout, NELEM); end
      checks++; if (ob !== 0) begin errors++; $display("FAIL full_out_order: got %0d bad expected 0", ob); end
      checks++; if (first_st_cyc - last_ld_cyc !== CC + 1) begin
         errors++; $display("FAIL full_compute_gap: got %0d expected %0d", first_st_cyc - last_ld_cyc, CC + 1); end
      checks++; if ({busy, err_unexp} !== 2'b00) begin errors++; $display("FAIL full_idle_after: got %b expected 00", {busy, err_unexp}); end
   endtask

   task automatic test_backpressure();
      int nw, ni, nst, nd, nout, lb, ob, bs; bit bo, tmo;
      do_job(1'b0, 1'b0, 1, 2 * NELEM, nw, ni, nst, nd, nout, lb, ob, bs, bo, tmo);
      checks++; if (bs !== 4) begin errors++; $display("FAIL bp_stall_stores: got %0d expected 4", bs); end
      checks++; if (bo !== 1'b1) begin errors++; $display("FAIL bp_out_valid: got %b expected 1", bo); end
      checks++; if (nst !== NELEM) begin errors++; $display("FAIL bp_stores: got %0d expected %0d", nst, NELEM); end
      checks++; if (nout !== NELEM || ob !== 0) begin errors++; $display("FAIL bp_results: got %0d out %0d bad expected %0d out 0 bad", nout, ob, NELEM); end
      checks++; if (tmo !== 1'b0 || nd !== 1) begin errors++; $display("FAIL bp_done: got %0d expected 1", nd); end
   endtask

   task automatic test_gaps();
      int nw, ni, nst, nd, nout, lb, ob, bs; bit bo, tmo;
      do_job(1'b0, 1'b1, 2, 2 * NELEM, nw, ni, nst, nd, nout, lb, ob, bs, bo, tmo);
      checks++; if (nw !== NELEM || ni !== NELEM) begin errors++; $display("FAIL gaps_loads: got %0d/%0d expected %0d/%0d", nw, ni, NELEM, NELEM); end
      checks++; if (lb !== 0) begin errors++; $display("FAIL gaps_load_data: got %0d bad expected 0", lb); end
      checks++; if (nout !== NELEM || ob !== 0) begin errors++; $display("FAIL gaps_results: got %0d out %0d bad expected %0d out 0 bad", nout, ob, NELEM); end
      checks++; if (tmo !== 1'b0 || nd !== 1) begin errors++; $display("FAIL gaps_done: got %0d expected 1", nd); end
   endtask

   task automatic test_keep_w();
      int nw, ni, nst, nd, nout, lb, ob, bs; bit bo, tmo;
      do_job(1'b1, 1'b0, 0, NELEM, nw, ni, nst, nd, nout, lb, ob, bs, bo, tmo);
      checks++; if (nw !== 0) begin errors++; $display("FAIL keep_skip_weights: got %0d expected 0", nw); end
      checks++; if (ni !== NELEM || lb !== 0) begin errors++; $display("FAIL keep_inputs: got %0d (%0d bad) expected %0d", ni, lb, NELEM); end
      checks++; if (nout !== NELEM || ob !== 0 || nd !== 1) begin errors++; $display("FAIL keep_results: got %0d out %0d done expected %0d out 1 done", nout, nd, NELEM); end
      @(posedge clk); #1; rst_n = 1'b0;
      @(posedge clk); #1; rst_n = 1'b1;
      do_job(1'b1, 1'b0, 0, 2 * NELEM, nw, ni, nst, nd, nout, lb, ob, bs, bo, tmo);
      checks++; if (nw !== NELEM || ni !== NELEM) begin errors++; $display("FAIL keep_after_reset: got %0d/%0d expected %0d/%0d", nw, ni, NELEM, NELEM); end
      checks++; if (nout !== NELEM || ob !== 0 || nd !== 1) begin errors++; $display("FAIL keep_after_reset_results: got %0d out %0d done expected %0d out 1 done", nout, nd, NELEM); end
   endtask

   task automatic test_reset_mid_job();
      int nw, ni, nst, nd, nout, lb, ob, bs, d0, i0; bit bo, tmo;
      logic [18:0] z;
      d0 = mon_nd; i0 = mon_ni;
      out_ready = 1'b1;
      pulse_start(1'b0);
      stream(NELEM + 7, 1'b0);
      rst_n = 1'b0; in_valid = 1'b1; in_data = 4'($urandom_range(1, 15));
      @(negedge clk);
      z = {busy, done, in_ready, sa_load_weights, sa_load_inputs, sa_store_outputs, out_valid, sa_data_in, out_data};
      checks++; if (z !== '0) begin errors++; $display("FAIL midrst_outputs: got %h expected 0", z); end
      @(posedge clk); #1;
      rst_n = 1'b1; in_valid = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0 || mon_nd !== d0) begin errors++; $display("FAIL midrst_abandon: got busy %b done %0d expected busy 0 done 0", busy, mon_nd - d0); end
      checks++; if (mon_ni - i0 !== 7) begin errors++; $display("FAIL midrst_inputs: got %0d expected 7", mon_ni - i0); end
      do_job(1'b1, 1'b0, 0, 2 * NELEM, nw, ni, nst, nd, nout, lb, ob, bs, bo, tmo);
      checks++; if (nw !== NELEM || ni !== NELEM || lb !== 0) begin errors++; $display("FAIL midrst_next_loads: got %0d/%0d (%0d bad) expected %0d/%0d", nw, ni, lb, NELEM, NELEM); end
      checks++; if (nout !== NELEM || ob !== 0 || nd !== 1) begin errors++; $display("FAIL midrst_next_results: got %0d out %0d done expected %0d out 1 done", nout, nd, NELEM); end
   endtask

   task automatic test_spurious();
      @(negedge clk); spur = 1'b1;
      @(negedge clk); spur = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         checks++; if (err_unexp !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL spur_flag_cycle%0d: got err %b valid %b expected err 1 valid 0", k, err_unexp, out_valid); end
      end
      @(posedge clk); #1; rst_n = 1'b0;
      @(negedge clk);
      checks++; if (err_unexp !== 1'b0) begin errors++; $display("FAIL spur_cleared_by_reset: got %b expected 0", err_unexp); end
      @(posedge clk); #1; rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_full_job();
      test_backpressure();
      test_gaps();
      test_keep_w();
      test_reset_mid_job();
      test_spurious();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
